// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the M stage (master) and data memory (slave).
interface memory_access_stage_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/memory_access_stage.sv
// RV32I memory stage: drives the req/ack data bus, stalls upstream while an access is
// outstanding, completes hung accesses after TIMEOUT wait states, and registers MEM/WB.
module memory_access_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [DATA_W-1:0]     ALUResultM,
  input  logic [DATA_W-1:0]     WriteDataM,
  input  logic [DATA_W-1:0]     PCPlus4M,
  input  logic [4:0]            RDM,
  memory_access_stage_if.master dmem,
  output logic                  StallM,
  output logic                  MemFaultM,
  output logic                  RegWriteW,
  output logic                  ResultSrcW,
  output logic [DATA_W-1:0]     ReadDataW,
  output logic [DATA_W-1:0]     ALUResultW,
  output logic [DATA_W-1:0]     PCPlus4W,
  output logic [4:0]            RDW
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WCNT_LAST  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic             TIMEOUT_EN = (TIMEOUT != 0) ? 1'b1 : 1'b0;

  function automatic logic [DATA_W-1:0] wordAlign(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

  function automatic logic [DATA_W-1:0] loadData(input logic isLoadOp, input logic acked,
                                                 input logic [DATA_W-1:0] rdata);
    return (isLoadOp && acked) ? rdata : '0;
  endfunction

  logic [0:0]       state;
  logic [0:0]       stateNxt;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] wcntNxt;

  logic memOp;
  logic isLoad;
  logic req;
  logic ackQ;
  logic timeoutHit;
  logic done;
  logic stall;

  logic              faultM;
  logic              regWrite_p1;
  logic              resultSrc_p1;
  logic [DATA_W-1:0] readData_p1;
  logic [DATA_W-1:0] aluResult_p1;
  logic [DATA_W-1:0] pcPlus4_p1;
  logic [4:0]        rd_p1;

  // Request side: a store wins over a load when both flags are set.
  assign memOp  = MemWriteM | ResultSrcM;
  assign isLoad = ResultSrcM & ~MemWriteM;
  assign req    = memOp & rst;
  assign ackQ   = req & dmem.dmem_ack;

  assign timeoutHit = req & (state == WAIT) & TIMEOUT_EN & (wcnt == WCNT_LAST) & ~ackQ;
  assign done       = ackQ | timeoutHit;
  assign stall      = req & ~done;

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = MemWriteM;
  assign dmem.dmem_addr  = wordAlign(ALUResultM);
  assign dmem.dmem_wdata = WriteDataM;

  always_comb begin
    stateNxt = state;
    wcntNxt  = wcnt;
    case (state)
      IDLE: begin
        if (req && !ackQ) begin
          stateNxt = WAIT;
          wcntNxt  = '0;
        end
      end
      WAIT: begin
        // Losing the request mid-wait cannot happen with held inputs; recover to IDLE anyway.
        if (!req || done) begin
          stateNxt = IDLE;
        end else begin
          wcntNxt = wcnt + 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wcnt   <= '0;
      faultM <= 1'b0;
    end else begin
      state <= stateNxt;
      wcnt  <= wcntNxt;
      if (timeoutHit) begin
        faultM <= 1'b1;
      end
    end
  end

  // MEM/WB boundary: a stalled cycle injects a bubble, other fields hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite_p1  <= 1'b0;
      resultSrc_p1 <= 1'b0;
      readData_p1  <= '0;
      aluResult_p1 <= '0;
      pcPlus4_p1   <= '0;
      rd_p1        <= '0;
    end else if (stall) begin
      regWrite_p1  <= 1'b0;
      resultSrc_p1 <= 1'b0;
    end else begin
      regWrite_p1  <= RegWriteM;
      resultSrc_p1 <= ResultSrcM;
      readData_p1  <= loadData(isLoad, ackQ, dmem.dmem_rdata);
      aluResult_p1 <= ALUResultM;
      pcPlus4_p1   <= PCPlus4M;
      rd_p1        <= RDM;
    end
  end

  assign StallM     = stall;
  assign MemFaultM  = faultM;
  assign RegWriteW  = regWrite_p1;
  assign ResultSrcW = resultSrc_p1;
  assign ReadDataW  = readData_p1;
  assign ALUResultW = aluResult_p1;
  assign PCPlus4W   = pcPlus4_p1;
  assign RDW        = rd_p1;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed ops with a per-cycle reference model plus literal checks.
module tb_memory_access_stage;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RDM;
  logic        StallM, MemFaultM, RegWriteW, ResultSrcW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RDW;

  int   total = 0;
  int   bad   = 0;
  logic running = 1'b0;

  memory_access_stage_if #(.DATA_W(DATA_W)) dmem ();

  memory_access_stage #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteM (RegWriteM),
    .ResultSrcM(ResultSrcM),
    .MemWriteM (MemWriteM),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .PCPlus4M  (PCPlus4M),
    .RDM       (RDM),
    .dmem      (dmem),
    .StallM    (StallM),
    .MemFaultM (MemFaultM),
    .RegWriteW (RegWriteW),
    .ResultSrcW(ResultSrcW),
    .ReadDataW (ReadDataW),
    .ALUResultW(ALUResultW),
    .PCPlus4W  (PCPlus4W),
    .RDW       (RDW)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts request cycles of the current access instead of tracking states.
  logic        mRw, mRs, mFault;
  logic [4:0]  mRd;
  logic [31:0] mAlu, mPc, mRdat;
  int          mCyc;

  initial begin
    logic eReq, eAck, eTo, eStall;
    int   eCyc;
    mRw = 0; mRs = 0; mFault = 0; mRd = 0; mAlu = 0; mPc = 0; mRdat = 0; mCyc = 0;
    forever begin
      @(negedge clk);
      if (running) begin
        if (!rst) begin
          mRw = 0; mRs = 0; mFault = 0; mRd = 0; mAlu = 0; mPc = 0; mRdat = 0; mCyc = 0;
        end
        eReq   = rst && (MemWriteM || ResultSrcM);
        eAck   = eReq && dmem.dmem_ack;
        eCyc   = eReq ? mCyc + 1 : 0;
        eTo    = eReq && !eAck && (TIMEOUT != 0) && (eCyc == TIMEOUT + 1);
        eStall = eReq && !eAck && !eTo;

        check("m_req",    dmem.dmem_req, eReq);
        check("m_stall",  StallM,        eStall);
        check("m_fault",  MemFaultM,     mFault);
        check("m_rw_w",   RegWriteW,     mRw);
        check("m_rs_w",   ResultSrcW,    mRs);
        check("m_rdat_w", ReadDataW,     mRdat);
        check("m_alu_w",  ALUResultW,    mAlu);
        check("m_pc_w",   PCPlus4W,      mPc);
        check("m_rd_w",   RDW,           mRd);
        if (eReq) begin
          check("m_we",    dmem.dmem_we,    MemWriteM);
          check("m_addr",  dmem.dmem_addr,  ALUResultM & 32'hFFFF_FFFC);
          check("m_wdata", dmem.dmem_wdata, WriteDataM);
        end

        if (rst) begin
          if (eStall) begin
            mRw  = 0;
            mRs  = 0;
            mCyc = eCyc;
          end else begin
            mRw   = RegWriteM;
            mRs   = ResultSrcM;
            mAlu  = ALUResultM;
            mPc   = PCPlus4M;
            mRd   = RDM;
            mRdat = (ResultSrcM && !MemWriteM && eAck) ? dmem.dmem_rdata : 32'h0;
            mCyc  = 0;
          end
          if (eTo) mFault = 1;
        end
      end
    end
  end

  // Holds one op in M until the DUT stops stalling; ack is given on request cycle ackAt (-1 = never).
  task automatic issueOp(input logic rw, input logic rs, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input int ackAt, input logic [31:0] rdata,
                         output int stalls, output logic [31:0] addrSeen);
    logic st;
    logic fin;
    RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RDM = rd;
    stalls = 0;
    fin = 1'b0;
    addrSeen = 32'h0;
    for (int k = 0; k < 64 && !fin; k++) begin
      dmem.dmem_ack   = (k == ackAt);
      dmem.dmem_rdata = (k == ackAt) ? rdata : (32'hA5A5_0000 | 32'(k));
      @(negedge clk);
      st = StallM;
      if (k == 0) addrSeen = dmem.dmem_addr;
      @(posedge clk);
      #1;
      if (st) stalls++;
      else fin = 1'b1;
    end
    dmem.dmem_ack = 1'b0;
    check("op_completes", {31'd0, fin}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          stSum;
    logic [31:0] a;
    rst = 1'b1;
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0;
    ALUResultM = 0; WriteDataM = 0; PCPlus4M = 0; RDM = 0;
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = 32'h0;
    #2 rst = 1'b0;
    running = 1'b1;
    #1;
    check("rst_stall", StallM, 32'd0);
    check("rst_req",   dmem.dmem_req, 32'd0);
    check("rst_rw",    RegWriteW, 32'd0);
    check("rst_fault", MemFaultM, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // ALU op
    issueOp(1, 0, 0, 32'h0000_002A, 32'h0, 32'h0000_0104, 5'd5, -1, 32'h0, st, a);
    check("t1_stalls", st, 32'd0);
    check("t1_rw",  RegWriteW,  32'd1);
    check("t1_alu", ALUResultW, 32'h0000_002A);
    check("t1_rd",  RDW,        32'd5);

    // Zero-wait load at unaligned address
    issueOp(1, 1, 0, 32'h0000_1003, 32'h0, 32'h0000_0108, 5'd6, 0, 32'hDEAD_BEEF, st, a);
    check("t2_addr",   a,          32'h0000_1000);
    check("t2_stalls", st,         32'd0);
    check("t2_rdat",   ReadDataW,  32'hDEAD_BEEF);
    check("t2_rs",     ResultSrcW, 32'd1);

    // Store acked on the 4th request cycle
    issueOp(0, 0, 1, 32'h0000_2000, 32'h1234_5678, 32'h0000_010C, 5'd0, 3, 32'h0, st, a);
    check("t3_stalls", st,         32'd3);
    check("t3_rw",     RegWriteW,  32'd0);
    check("t3_alu",    ALUResultW, 32'h0000_2000);
    check("t3_rdat",   ReadDataW,  32'h0);

    // Load that never gets an ack
    issueOp(1, 1, 0, 32'h0000_3000, 32'h0, 32'h0000_0110, 5'd7, -1, 32'h0, st, a);
    check("t4_stalls", st,        32'd16);
    check("t4_fault",  MemFaultM, 32'd1);
    check("t4_rdat",   ReadDataW, 32'h0);
    check("t4_rw",     RegWriteW, 32'd1);
    issueOp(1, 0, 0, 32'h0000_0055, 32'h0, 32'h0000_0114, 5'd8, -1, 32'h0, st, a);
    check("t4_sticky", MemFaultM, 32'd1);
    check("t4_resume", st,        32'd0);

    // Reset during the 2nd WAIT cycle
    RegWriteM = 1; ResultSrcM = 1; MemWriteM = 0;
    ALUResultM = 32'h0000_4000; WriteDataM = 0; PCPlus4M = 32'h0000_0118; RDM = 5'd9;
    dmem.dmem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_req",   dmem.dmem_req, 32'd0);
    check("t5_stall", StallM,     32'd0);
    check("t5_fault", MemFaultM,  32'd0);
    check("t5_rw",    RegWriteW,  32'd0);
    check("t5_rs",    ResultSrcW, 32'd0);
    check("t5_rdat",  ReadDataW,  32'h0);
    check("t5_alu",   ALUResultW, 32'h0);
    check("t5_pc",    PCPlus4W,   32'h0);
    check("t5_rd",    RDW,        32'd0);
    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    issueOp(1, 0, 0, 32'h0000_0077, 32'h0, 32'h0000_011C, 5'd10, -1, 32'h0, st, a);
    check("t5_nostall", st,         32'd0);
    check("t5_alu2",    ALUResultW, 32'h0000_0077);
    check("t5_rd2",     RDW,        32'd10);
    issueOp(1, 1, 0, 32'h0000_4800, 32'h0, 32'h0000_0120, 5'd11, 1, 32'hCAFE_0001, st, a);
    check("t5_ld_stalls", st,        32'd1);
    check("t5_ld_rdat",   ReadDataW, 32'hCAFE_0001);

    // Back-to-back loads, then a spurious ack on a non-memory op
    stSum = 0;
    issueOp(1, 1, 0, 32'h0000_5000, 32'h0, 32'h0000_0124, 5'd12, 0, 32'h1111_1111, st, a);
    stSum += st;
    check("t6_a_rdat", ReadDataW, 32'h1111_1111);
    check("t6_a_rd",   RDW,       32'd12);
    issueOp(1, 1, 0, 32'h0000_5004, 32'h0, 32'h0000_0128, 5'd14, 2, 32'h2222_2222, st, a);
    stSum += st;
    check("t6_b_rdat", ReadDataW, 32'h2222_2222);
    check("t6_b_rd",   RDW,       32'd14);
    issueOp(1, 0, 0, 32'h0000_0060, 32'h0, 32'h0000_012C, 5'd13, 0, 32'hBAD0_BAD0, st, a);
    stSum += st;
    check("t6_spur_rdat", ReadDataW, 32'h0);
    check("t6_spur_rd",   RDW,       32'd13);
    check("t6_stall_sum", stSum,     32'd2);
    check("t6_fault",     MemFaultM, 32'd0);

    RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
